// File: rtl/dispatch_queue.sv
// dispatch_queue: DEPTH-entry in-order FIFO between decode and rename/dispatch.
// Issues at most one head entry per cycle when ROB, free list and target RS
// can all accept it, drives the rename/dispatch write enables, supports a
// full squash, tracks stalled head cycles and flags illegal RS classes.
module dispatch_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 64,
  parameter int NUM_RS    = 4,
  parameter int CNT_W     = 32,
  localparam int CLASS_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1,
  localparam int PTR_W    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [4:0]           in_rd,
  input  logic [CLASS_W-1:0]   in_class,
  input  logic                 free_empty,
  input  logic                 rob_full,
  input  logic [NUM_RS-1:0]    rs_full,
  output logic                 head_valid,
  output logic [PAYLOAD_W-1:0] head_payload,
  output logic [4:0]           head_rd,
  output logic                 dispatch_fire,
  output logic [NUM_RS-1:0]    rs_we,
  output logic                 rob_we,
  output logic                 rat_we,
  output logic                 free_deq,
  output logic [PTR_W-1:0]     occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 err_class
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Entry storage; pointers carry one extra wrap bit to tell full from empty.
  logic [PAYLOAD_W-1:0] r_payload_mem [DEPTH];
  logic [4:0]           r_rd_mem      [DEPTH];
  logic [CLASS_W-1:0]   r_class_mem   [DEPTH];

  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic                 r_ready_en;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic                 r_err_class;

  logic [ADDR_W-1:0]    w_rd_addr;
  logic [ADDR_W-1:0]    w_wr_addr;
  logic [PTR_W-1:0]     w_occupancy;
  logic                 w_full;
  logic                 w_head_valid;
  logic [CLASS_W-1:0]   w_head_class;
  logic [4:0]           w_head_rd;
  logic [NUM_RS-1:0]    w_rs_hit;
  logic                 w_head_legal;
  logic                 w_head_rs_full;
  logic                 w_preg_blocked;
  logic                 w_can;
  logic                 w_fire;
  logic                 w_bad_pop;
  logic                 w_pop;
  logic                 w_enq;
  logic                 w_stall;

  assign w_rd_addr   = r_rd_ptr[ADDR_W-1:0];
  assign w_wr_addr   = r_wr_ptr[ADDR_W-1:0];
  assign w_occupancy = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_occupancy == PTR_W'(DEPTH));
  assign w_head_valid = (w_occupancy != '0);

  // Head fields come straight from storage at the read pointer; an entry
  // written at one edge is only visible after that edge (no bypass).
  assign w_head_class = r_class_mem[w_rd_addr];
  assign w_head_rd    = r_rd_mem[w_rd_addr];
  assign head_payload = r_payload_mem[w_rd_addr];
  assign head_rd      = w_head_rd;
  assign head_valid   = w_head_valid;
  assign occupancy    = w_occupancy;

  // in_ready depends only on registered state; r_ready_en keeps it low
  // during reset and until the first clock after release.
  assign in_ready = r_ready_en & ~w_full;
  assign w_enq    = in_valid & in_ready & ~flush;

  // Per-RS decode of the head class: selects the full flag and write enable.
  // A class with no matching RS decodes to all zeros, which marks it illegal.
  for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_rs
    assign w_rs_hit[gi] = (w_head_class == CLASS_W'(gi));
    assign rs_we[gi]    = w_fire & w_rs_hit[gi];
  end

  assign w_head_legal   = |w_rs_hit;
  assign w_head_rs_full = |(w_rs_hit & rs_full);

  // Only instructions that write a register need a free physical register.
  assign w_preg_blocked = (w_head_rd != 5'd0) & free_empty;

  assign w_can  = w_head_valid & ~flush & ~rob_full & ~w_head_rs_full & ~w_preg_blocked;
  assign w_fire = w_can & w_head_legal;

  // Illegal heads are discarded in one cycle without touching any resource.
  assign w_bad_pop = w_head_valid & ~flush & ~w_head_legal;
  assign w_pop     = w_fire | w_bad_pop;

  // A legal head that could not leave this cycle counts as a stall.
  assign w_stall = w_head_valid & ~flush & ~w_fire & w_head_legal;

  assign dispatch_fire = w_fire;
  assign rob_we        = w_fire;
  assign rat_we        = w_fire & (w_head_rd != 5'd0);
  assign free_deq      = w_fire & (w_head_rd != 5'd0);
  assign stall_cnt     = r_stall_cnt;
  assign err_class     = r_err_class;

  // Entry write port: storage itself needs no reset, validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_payload_mem[w_wr_addr] <= in_payload;
      r_rd_mem[w_wr_addr]      <= in_rd;
      r_class_mem[w_wr_addr]   <= in_class;
    end
  end

  // Read/write pointer update; flush squashes everything including this cycle's enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  // Ready enable: held low in reset, rises on the first clock afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Sticky illegal-class flag; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_class <= 1'b0;
    end else if (w_bad_pop) begin
      r_err_class <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the dispatch buffer.
module tb_dispatch_queue;

  localparam int DEPTH   = 4;
  localparam int PW      = 64;
  localparam int NRS     = 5;
  localparam int CW      = 3;
  localparam int CNTW    = 4;
  localparam int SAT     = 15;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic [4:0]    in_rd;
  logic [CW-1:0] in_class;
  logic          free_empty;
  logic          rob_full;
  logic [NRS-1:0] rs_full;
  logic          head_valid;
  logic [PW-1:0] head_payload;
  logic [4:0]    head_rd;
  logic          dispatch_fire;
  logic [NRS-1:0] rs_we;
  logic          rob_we;
  logic          rat_we;
  logic          free_deq;
  logic [2:0]    occupancy;
  logic [CNTW-1:0] stall_cnt;
  logic          err_class;

  int n_pass;
  int n_total;

  dispatch_queue #(
    .DEPTH(DEPTH), .PAYLOAD_W(PW), .NUM_RS(NRS), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_rd(in_rd), .in_class(in_class),
    .free_empty(free_empty), .rob_full(rob_full), .rs_full(rs_full),
    .head_valid(head_valid), .head_payload(head_payload), .head_rd(head_rd),
    .dispatch_fire(dispatch_fire), .rs_we(rs_we), .rob_we(rob_we),
    .rat_we(rat_we), .free_deq(free_deq), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .err_class(err_class)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a plain queue of entries plus the two status values.
  logic [PW-1:0] q_pay [$];
  logic [4:0]    q_rd  [$];
  logic [CW-1:0] q_cls [$];
  int            m_stall;
  bit            m_err;
  bit            m_ready_en;

  bit            e_head, e_ready, e_legal, e_fire, e_ipop, e_enq;
  logic [PW-1:0] e_pay;
  logic [4:0]    e_rd;
  logic [CW-1:0] e_cls;
  logic [NRS-1:0] e_rs_we;
  logic [11:0]   e_ctrl;

  function automatic void model_eval();
    e_head  = (q_pay.size() != 0);
    e_ready = m_ready_en && (q_pay.size() != DEPTH);
    e_legal = 1'b0;
    e_fire  = 1'b0;
    e_pay   = '0;
    e_rd    = '0;
    e_cls   = '0;
    if (e_head) begin
      e_pay   = q_pay[0];
      e_rd    = q_rd[0];
      e_cls   = q_cls[0];
      e_legal = (int'(e_cls) < NRS);
    end
    if (e_legal) begin
      e_fire = !flush && !rob_full && !rs_full[e_cls] && !(e_rd != 0 && free_empty);
    end
    e_ipop  = e_head && !e_legal && !flush;
    e_enq   = in_valid && e_ready && !flush;
    e_rs_we = e_fire ? (NRS'(1) << e_cls) : '0;
    e_ctrl  = {e_head, e_ready, e_fire, e_fire, e_fire && (e_rd != 0),
               e_fire && (e_rd != 0), e_rs_we, m_err};
  endfunction

  task automatic clear_model();
    q_pay.delete();
    q_rd.delete();
    q_cls.delete();
    m_stall    = 0;
    m_err      = 1'b0;
    m_ready_en = 1'b0;
  endtask

  // Advance one clock, applying the same inputs to the model; returns at edge+1.
  task automatic tick();
    bit stall_inc;
    model_eval();
    stall_inc = e_legal && !flush && !e_fire;
    @(posedge clk);
    if (rst_n) begin
      m_ready_en = 1'b1;
      if (flush) begin
        q_pay.delete();
        q_rd.delete();
        q_cls.delete();
      end else begin
        if (e_fire || e_ipop) begin
          void'(q_pay.pop_front());
          void'(q_rd.pop_front());
          void'(q_cls.pop_front());
        end
        if (e_enq) begin
          q_pay.push_back(in_payload);
          q_rd.push_back(in_rd);
          q_cls.push_back(in_class);
        end
      end
      if (e_ipop) m_err = 1'b1;
      if (stall_inc && m_stall < SAT) m_stall++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_payload = '0;
    in_rd      = '0;
    in_class   = '0;
    free_empty = 1'b0;
    rob_full   = 1'b0;
    rs_full    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic offer(input logic [PW-1:0] p, input logic [4:0] rd, input logic [CW-1:0] cls);
    in_valid   = 1'b1;
    in_payload = p;
    in_rd      = rd;
    in_class   = cls;
  endtask

  // T1: asynchronous reset in the middle of traffic.
  task automatic test_reset();
    do_reset();
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(64'h1000 + 64'(i), 5'd1, 3'd0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_total++;
    if (occupancy !== 3'd3) $display("FAIL rst_preload occupancy got=%0d exp=3", occupancy);
    else n_pass++;
    rob_full = 1'b0;
    rst_n = 1'b0;
    clear_model();
    #1;
    n_total++;
    if ({occupancy, head_valid, in_ready} !== 5'b0)
      $display("FAIL rst_state occ/head/ready got=%0d/%0b/%0b exp=0/0/0", occupancy, head_valid, in_ready);
    else n_pass++;
    n_total++;
    if ({dispatch_fire, rob_we, rat_we, free_deq, rs_we, stall_cnt, err_class} !== '0)
      $display("FAIL rst_enables fire=%0b rob=%0b rat=%0b fdq=%0b rs_we=%b stall=%0d err=%0b exp all 0",
               dispatch_fire, rob_we, rat_we, free_deq, rs_we, stall_cnt, err_class);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL rst_release_ready_early got=%0b exp=0", in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_release_ready got=%0b exp=1", in_ready);
    else n_pass++;
    $display("[reset] done");
  endtask

  // T2: fill to DEPTH with dispatch blocked, then drain across the wrap.
  task automatic test_fill_wrap();
    logic [PW-1:0] pl [6];
    int idx;
    int k;
    for (int i = 0; i < 6; i++) pl[i] = {$urandom, $urandom};
    idle_inputs();
    rob_full = 1'b1;
    idx = 0;
    for (int c = 0; c < 10 && idx < 4; c++) begin
      offer(pl[idx], 5'd2, 3'd0);
      #1;
      if (in_ready) idx++;
      tick();
    end
    offer(pl[idx], 5'd2, 3'd0);
    #1;
    n_total++;
    if (in_ready !== 1'b0 || occupancy !== 3'd4)
      $display("FAIL fill_full ready/occ got=%0b/%0d exp=0/4", in_ready, occupancy);
    else n_pass++;
    tick();
    n_total++;
    if (occupancy !== 3'd4) $display("FAIL fill_hold occupancy got=%0d exp=4", occupancy);
    else n_pass++;
    rob_full = 1'b0;
    k = 0;
    for (int c = 0; c < 30 && k < 6; c++) begin
      if (idx < 6) offer(pl[idx], 5'd2, 3'd0);
      else in_valid = 1'b0;
      #1;
      if (dispatch_fire) begin
        n_total++;
        if (head_payload !== pl[k])
          $display("FAIL drain_order idx=%0d got=%h exp=%h", k, head_payload, pl[k]);
        else n_pass++;
        $display("[fill_wrap] dispatch %0d payload=%h", k, head_payload);
        k++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    n_total++;
    if (k !== 6) $display("FAIL drain_count got=%0d exp=6", k);
    else n_pass++;
  endtask

  // T3: rd=0 ignores free_empty; rd!=0 stalls on it.
  task automatic test_rd_zero();
    do_reset();
    free_empty = 1'b1;
    offer(64'hDEAD_0000_0000_0001, 5'd0, 3'd1);
    tick();
    in_valid = 1'b0;
    #1;
    n_total++;
    if ({dispatch_fire, rob_we, rat_we, free_deq, rs_we} !== {4'b1100, 5'b00010})
      $display("FAIL rd0_fire fire/rob/rat/fdq/rs_we got=%b%b%b%b/%b exp=1100/00010",
               dispatch_fire, rob_we, rat_we, free_deq, rs_we);
    else n_pass++;
    tick();
    offer(64'hDEAD_0000_0000_0002, 5'd5, 3'd1);
    tick();
    in_valid = 1'b0;
    #1;
    n_total++;
    if (dispatch_fire !== 1'b0 || stall_cnt !== 4'd0)
      $display("FAIL rd5_block fire/stall got=%0b/%0d exp=0/0", dispatch_fire, stall_cnt);
    else n_pass++;
    tick();
    n_total++;
    if (stall_cnt !== 4'd1) $display("FAIL rd5_stall1 got=%0d exp=1", stall_cnt);
    else n_pass++;
    tick();
    n_total++;
    if (stall_cnt !== 4'd2) $display("FAIL rd5_stall2 got=%0d exp=2", stall_cnt);
    else n_pass++;
    free_empty = 1'b0;
    #1;
    n_total++;
    if ({dispatch_fire, rob_we, rat_we, free_deq} !== 4'b1111)
      $display("FAIL rd5_fire fire/rob/rat/fdq got=%b%b%b%b exp=1111",
               dispatch_fire, rob_we, rat_we, free_deq);
    else n_pass++;
    tick();
    n_total++;
    if (stall_cnt !== 4'd2 || head_valid !== 1'b0)
      $display("FAIL rd5_after stall/head got=%0d/%0b exp=2/0", stall_cnt, head_valid);
    else n_pass++;
  endtask

  // T4: the head is routed only to its own RS, and only when that RS has room.
  task automatic test_rs_routing();
    idle_inputs();
    rs_full = 5'b00100;
    offer(64'h0000_BEEF_0000_0002, 5'd3, 3'd2);
    tick();
    in_valid = 1'b0;
    #1;
    n_total++;
    if (dispatch_fire !== 1'b0 || rs_we !== 5'b0)
      $display("FAIL rs_blocked fire/rs_we got=%0b/%b exp=0/00000", dispatch_fire, rs_we);
    else n_pass++;
    tick();
    rs_full = 5'b00000;
    #1;
    n_total++;
    if (rs_we !== 5'b00100 || dispatch_fire !== 1'b1)
      $display("FAIL rs_route rs_we/fire got=%b/%0b exp=00100/1", rs_we, dispatch_fire);
    else n_pass++;
    tick();
    n_total++;
    if (rs_we !== 5'b0 || head_valid !== 1'b0)
      $display("FAIL rs_one_cycle rs_we/head got=%b/%0b exp=00000/0", rs_we, head_valid);
    else n_pass++;
  endtask

  // T5: flush during a cycle that would both enqueue and dispatch.
  task automatic test_flush();
    idle_inputs();
    rob_full = 1'b1;
    offer(64'hF1, 5'd3, 3'd0);
    tick();
    offer(64'hF2, 5'd3, 3'd0);
    tick();
    rob_full = 1'b0;
    flush    = 1'b1;
    offer(64'hF3, 5'd3, 3'd0);
    #1;
    n_total++;
    if (occupancy !== 3'd2) $display("FAIL flush_pre occupancy got=%0d exp=2", occupancy);
    else n_pass++;
    n_total++;
    if ({dispatch_fire, rob_we, rat_we, free_deq, rs_we} !== '0)
      $display("FAIL flush_enables fire/rob/rat/fdq/rs_we got=%b%b%b%b/%b exp=0000/00000",
               dispatch_fire, rob_we, rat_we, free_deq, rs_we);
    else n_pass++;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_total++;
    if (occupancy !== 3'd0 || head_valid !== 1'b0)
      $display("FAIL flush_after occ/head got=%0d/%0b exp=0/0", occupancy, head_valid);
    else n_pass++;
    rob_full = 1'b1;
    offer(64'hF4, 5'd3, 3'd0);
    tick();
    in_valid = 1'b0;
    rob_full = 1'b0;
    #1;
    n_total++;
    if (head_payload !== 64'hF4 || occupancy !== 3'd1)
      $display("FAIL flush_refill payload/occ got=%h/%0d exp=f4/1", head_payload, occupancy);
    else n_pass++;
    tick();
  endtask

  // T6: illegal class pops with error flag; stall counter saturates and survives flush.
  task automatic test_sat_illegal();
    do_reset();
    offer(64'h0BAD, 5'd7, 3'd6);
    tick();
    in_valid = 1'b0;
    #1;
    n_total++;
    if ({head_valid, dispatch_fire, rob_we, rat_we, free_deq, rs_we, err_class} !== {1'b1, 10'b0})
      $display("FAIL illegal_head head/fire/rob/rat/fdq/rs_we/err got=%b/%b%b%b%b/%b/%b exp=1/0000/00000/0",
               head_valid, dispatch_fire, rob_we, rat_we, free_deq, rs_we, err_class);
    else n_pass++;
    tick();
    n_total++;
    if (err_class !== 1'b1 || occupancy !== 3'd0 || stall_cnt !== 4'd0)
      $display("FAIL illegal_pop err/occ/stall got=%0b/%0d/%0d exp=1/0/0", err_class, occupancy, stall_cnt);
    else n_pass++;
    rob_full = 1'b1;
    offer(64'h5A7, 5'd4, 3'd4);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_total++;
    if (stall_cnt !== 4'd15) $display("FAIL stall_sat got=%0d exp=15", stall_cnt);
    else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rob_full = 1'b0;
    #1;
    n_total++;
    if (stall_cnt !== 4'd15 || err_class !== 1'b1 || occupancy !== 3'd0)
      $display("FAIL flush_keeps stall/err/occ got=%0d/%0b/%0d exp=15/1/0", stall_cnt, err_class, occupancy);
    else n_pass++;
  endtask

  // Randomized traffic compared cycle by cycle with the queue model.
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid   = ($urandom_range(0, 99) < 60);
      in_payload = {$urandom, $urandom};
      in_rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      in_class   = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      free_empty = ($urandom_range(0, 99) < 20);
      rob_full   = ($urandom_range(0, 99) < 25);
      rs_full    = NRS'($urandom) & NRS'($urandom) & NRS'($urandom);
      flush      = ($urandom_range(0, 99) < 4);
      #1;
      model_eval();
      n_total++;
      if ({head_valid, in_ready, dispatch_fire, rob_we, rat_we, free_deq, rs_we, err_class} !== e_ctrl)
        $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", c,
                 {head_valid, in_ready, dispatch_fire, rob_we, rat_we, free_deq, rs_we, err_class}, e_ctrl);
      else n_pass++;
      n_total++;
      if (occupancy !== 3'(q_pay.size()) || stall_cnt !== 4'(m_stall))
        $display("FAIL rnd_occ_stall cyc=%0d got=%0d/%0d exp=%0d/%0d", c, occupancy, stall_cnt,
                 q_pay.size(), m_stall);
      else n_pass++;
      if (e_head) begin
        n_total++;
        if (head_payload !== e_pay || head_rd !== e_rd)
          $display("FAIL rnd_head cyc=%0d got=%h/%0d exp=%h/%0d", c, head_payload, head_rd, e_pay, e_rd);
        else n_pass++;
      end
      if (e_fire) $display("[random] cyc %0d dispatch payload=%h rd=%0d class=%0d", c, e_pay, e_rd, e_cls);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    idle_inputs();
    clear_model();
    test_reset();
    test_fill_wrap();
    test_rd_zero();
    test_rs_routing();
    test_flush();
    test_sat_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
